// File: rtl/fetch_control.sv
// rtl/fetch_control.sv - instruction fetch sequencer with 2-entry prefetch buffer
//
// Purpose: walks a program counter through instruction memory, buffering up to
// two {pc, instr} pairs for the decode stage. Fetch stops after a HALT opcode
// and restarts on start or redirect. Redirects flush all buffered entries.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, start_pc       - begin fetching at start_pc (IDLE/HALT only)
//   imem_pc, imem_instr   - instruction memory address / combinational read data
//   redirect_valid/_pc    - branch/jump redirect (FETCH/HALT only, beats start)
//   out_valid/_instr/_pc  - buffer head presented to decode
//   out_ready             - decode accepts head
//   busy, halted          - FETCH state / HALT with empty buffer
module fetch_control #(
  parameter int         PC_W    = 12,
  parameter int         INSTR_W = 16,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [PC_W-1:0]   pc, pc_next;

  logic [PC_W-1:0]    buf_pc    [2];
  logic [INSTR_W-1:0] buf_instr [2];
  logic               head;
  logic [1:0]         count;
  logic               tail;

  logic flush;
  logic push;
  logic pop;
  logic slot_free;
  logic halt_fetch;

  // Tail slot is the one after the head when a single entry is held; with
  // zero or two entries it coincides with the head slot.
  assign tail       = head ^ count[0];
  assign pop        = out_valid && out_ready;
  assign slot_free  = (count != 2'd2) || pop;
  assign halt_fetch = (imem_instr[15:12] == HALT_OP);

  assign imem_pc   = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = buf_instr[head];
  assign out_pc    = buf_pc[head];
  assign busy      = (state == FETCH);
  assign halted    = (state == HALT) && (count == 2'd0);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    flush      = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = start_pc;
          flush      = 1'b1;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
          flush   = 1'b1;
        end else if (slot_free) begin
          push = 1'b1;
          // HALT is buffered like any instruction but the PC parks on it.
          if (halt_fetch) state_next = HALT;
          else            pc_next    = pc + PC_W'(1);
        end
      end
      HALT: begin
        if (redirect_valid) begin
          state_next = FETCH;
          pc_next    = redirect_pc;
          flush      = 1'b1;
        end else if (start) begin
          state_next = FETCH;
          pc_next    = start_pc;
          flush      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= '0;
      head         <= 1'b0;
      count        <= 2'd0;
      buf_pc[0]    <= '0;
      buf_pc[1]    <= '0;
      buf_instr[0] <= '0;
      buf_instr[1] <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (push) begin
        buf_pc[tail]    <= pc;
        buf_instr[tail] <= imem_instr;
      end
      // A flush voids any handshake in the same cycle.
      if (flush) begin
        head  <= 1'b0;
        count <= 2'd0;
      end else begin
        if (pop) head <= ~head;
        if (push && !pop)      count <= count + 2'd1;
        else if (pop && !push) count <= count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// tb/tb_fetch_control.sv - directed self-checking bench for fetch_control
module tb_fetch_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] start_pc;
  logic [11:0] imem_pc;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic        out_ready;
  logic        busy;
  logic        halted;

  logic [15:0] mem [0:4095];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_pc];

  fetch_control dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_pc       (start_pc),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .busy           (busy),
    .halted         (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 | 16'(i);
    mem[0] = 16'h1438;
    mem[1] = 16'h282F;
    mem[2] = 16'h1221;
    mem[3] = 16'hF000;

    reset = 1'b1; start = 1'b0; start_pc = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", 32'(out_instr), 0);
    chk("rst_out_pc",    32'(out_pc),    0);
    chk("rst_busy",      32'(busy),      0);
    chk("rst_halted",    32'(halted),    0);
    chk("rst_imem_pc",   32'(imem_pc),   0);

    // redirect in IDLE is ignored
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 12'h123;
    step();
    chk("idle_redir_busy", 32'(busy),    0);
    chk("idle_redir_pc",   32'(imem_pc), 0);
    redirect_valid = 1'b0;

    // straight-line program ending in HALT
    start = 1'b1; start_pc = 12'h000; out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("p1_busy",      32'(busy),      1);
    chk("p1_imem_pc",   32'(imem_pc),   0);
    chk("p1_out_valid", 32'(out_valid), 0);
    step();
    chk("p1_v0",  32'(out_valid), 1);
    chk("p1_pc0", 32'(out_pc),    0);
    chk("p1_i0",  32'(out_instr), 32'h1438);
    step();
    chk("p1_pc1", 32'(out_pc),    1);
    chk("p1_i1",  32'(out_instr), 32'h282F);
    step();
    chk("p1_pc2", 32'(out_pc),    2);
    chk("p1_i2",  32'(out_instr), 32'h1221);
    step();
    chk("p1_pc3",     32'(out_pc),    3);
    chk("p1_i3",      32'(out_instr), 32'hF000);
    chk("p1_busy3",   32'(busy),      0);
    chk("p1_halted3", 32'(halted),    0);
    chk("p1_imem3",   32'(imem_pc),   3);
    step();
    chk("p1_valid_end", 32'(out_valid), 0);
    chk("p1_halted",    32'(halted),    1);
    chk("p1_imem_hold", 32'(imem_pc),   3);

    // back-pressure: buffer fills to two, then drains in order
    start = 1'b1; start_pc = 12'h010; out_ready = 1'b0;
    step();
    start = 1'b0;
    chk("bp_imem0", 32'(imem_pc), 32'h010);
    step();
    chk("bp_imem1", 32'(imem_pc), 32'h011);
    chk("bp_head1", 32'(out_pc),  32'h010);
    step();
    chk("bp_imem2", 32'(imem_pc), 32'h012);
    step();
    chk("bp_stall_imem",  32'(imem_pc),   32'h012);
    chk("bp_stall_head",  32'(out_pc),    32'h010);
    chk("bp_stall_valid", 32'(out_valid), 1);
    chk("bp_stall_instr", 32'(out_instr), 32'h1010);
    out_ready = 1'b1;
    step();
    chk("bp_d1_pc",   32'(out_pc),  32'h011);
    chk("bp_d1_imem", 32'(imem_pc), 32'h013);
    step();
    chk("bp_d2_pc",    32'(out_pc),    32'h012);
    chk("bp_d2_instr", 32'(out_instr), 32'h1012);
    step();
    chk("bp_d3_pc", 32'(out_pc), 32'h013);

    // redirect with two entries buffered and decode ready
    redirect_valid = 1'b1; redirect_pc = 12'h100;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid", 32'(out_valid), 0);
    chk("rd_imem",  32'(imem_pc),   32'h100);
    chk("rd_busy",  32'(busy),      1);
    step();
    chk("rd_valid2", 32'(out_valid), 1);
    chk("rd_pc",     32'(out_pc),    32'h100);
    chk("rd_instr",  32'(out_instr), 32'h1100);

    // reset mid-FETCH with one entry held
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_busy",  32'(busy),      0);
    chk("mr_imem",  32'(imem_pc),   0);
    chk("mr_pc",    32'(out_pc),    0);

    // PC wrap, plus start ignored while fetching
    start = 1'b1; start_pc = 12'hFFE;
    step();
    start = 1'b0;
    chk("wr_imem0", 32'(imem_pc), 32'hFFE);
    step();
    chk("wr_pc0", 32'(out_pc), 32'hFFE);
    start = 1'b1; start_pc = 12'h200;
    step();
    start = 1'b0;
    chk("wr_pc1",        32'(out_pc),  32'hFFF);
    chk("wr_start_ign",  32'(imem_pc), 32'h000);
    step();
    chk("wr_pc2",    32'(out_pc),    32'h000);
    chk("wr_instr2", 32'(out_instr), 32'h1438);
    step();
    chk("wr_pc3", 32'(out_pc), 32'h001);

    // reach HALT via redirect, then start + redirect together
    redirect_valid = 1'b1; redirect_pc = 12'h003;
    step();
    redirect_valid = 1'b0;
    chk("h_imem", 32'(imem_pc), 3);
    step();
    chk("h_pc",   32'(out_pc), 3);
    chk("h_busy", 32'(busy),   0);
    step();
    chk("h_halted", 32'(halted), 1);
    start = 1'b1; start_pc = 12'h050;
    redirect_valid = 1'b1; redirect_pc = 12'h080;
    step();
    start = 1'b0; redirect_valid = 1'b0;
    chk("sr_imem", 32'(imem_pc), 32'h080);
    chk("sr_busy", 32'(busy),    1);
    step();
    chk("sr_pc", 32'(out_pc), 32'h080);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 SHALL have parameter PC_W, default 12, program counter / instruction memory address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-003 SHALL have parameter HALT_OP, default 4'b1111, opcode field value (instr[15:12]) that stops fetching.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin fetching at start_pc; honoured in IDLE or HALT only.
REQ-007 SHALL have port start_pc  input  PC_W  first fetch address.
REQ-008 SHALL have port imem_pc  output  PC_W  address to instruction memory; equals internal PC register.
REQ-009 SHALL have port imem_instr  input  INSTR_W  instruction memory read data, combinational from imem_pc in the same cycle.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-011 SHALL have port redirect_pc  input  PC_W  redirect target address.
REQ-012 SHALL have port out_valid  output  1  buffer head holds a valid instruction.
REQ-013 SHALL have port out_instr  output  INSTR_W  buffer head instruction.
REQ-014 SHALL have port out_pc  output  PC_W  address of out_instr.
REQ-015 SHALL have port out_ready  input  1  decode accepts head when out_valid and out_ready are both high.
REQ-016 SHALL have port busy  output  1  high in state FETCH.
REQ-017 SHALL have port halted  output  1  high when state is HALT and buffer is empty.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, HALT; IDLE->FETCH on start; FETCH->HALT on fetching HALT_OP; HALT->FETCH on start or redirect_valid; no other transitions except reset.
REQ-019 SHALL on start in IDLE/HALT load PC <= start_pc, flush the buffer and enter FETCH next cycle; start in FETCH is ignored.
REQ-020 SHALL contain a 2-entry FIFO of {pc, instr}; out_valid = (count != 0); out_instr/out_pc driven from the head entry.
REQ-021 SHALL in FETCH push {PC, imem_instr} and advance PC <= PC + 1 in any cycle where count < 2, or count == 2 and a pop occurs that cycle.
REQ-022 SHALL wrap PC from 2^PC_W-1 to 0 with no flag.
REQ-023 SHALL when no push slot exists hold PC and fetch nothing (stall); imem_pc remains stable.
REQ-024 SHALL when the pushed instruction has instr[15:12] == HALT_OP push it, hold PC at the HALT address, and enter HALT; the HALT instruction is delivered to decode like any other.
REQ-025 SHALL pop the head on out_valid && out_ready; simultaneous push and pop leaves count unchanged.
REQ-026 SHALL on redirect_valid in FETCH or HALT flush all entries, load PC <= redirect_pc, and be in FETCH next cycle; no push occurs in the redirect cycle; a handshake in the redirect cycle is void (entry discarded, not counted as delivered).
REQ-027 SHALL ignore redirect_valid in IDLE; redirect_valid takes priority over start when both high.
REQ-028 SHALL give latency: start sampled at cycle N -> imem_pc = start_pc at N+1 -> out_valid at N+2 with out_pc = start_pc.
REQ-029 SHALL sustain one instruction per cycle with out_ready held high.
REQ-030 SHALL never present an instruction whose address was fetched before the last flush.

Reset
REQ-031 SHALL on reset high at a clock edge set state IDLE, PC 0, count 0, out_valid 0, out_instr 0, out_pc 0, busy 0, halted 0, regardless of state, start or redirect_valid.
REQ-032 SHALL abandon any in-progress fetch on reset mid-operation; no entry survives.

Verification
REQ-033 SHALL cover: reset, then start with start_pc=0, out_ready=1, memory 0x1438,0x282F,0x1221,0xF000 -> out_pc 0,1,2,3 on consecutive cycles from N+2, halted=1 after 0xF000 accepted, imem_pc held at 3.
REQ-034 SHALL cover: out_ready=0 from start -> count saturates at 2, imem_pc stops at start_pc+2, out_pc held at start_pc; out_ready=1 -> in-order delivery with no loss or duplication.
REQ-035 SHALL cover: redirect_valid with redirect_pc=0x100 while 2 entries buffered and out_ready=1 -> entry discarded, next out_valid shows out_pc=0x100 two cycles later.
REQ-036 SHALL cover: start_pc=0xFFE with non-HALT memory -> out_pc sequence 0xFFE,0xFFF,0x000,0x001.
REQ-037 SHALL cover: reset asserted mid-FETCH with 1 entry buffered -> next cycle out_valid=0, busy=0, imem_pc=0; start afterwards behaves as REQ-028.
REQ-038 SHALL cover: start and redirect_valid both high in HALT -> PC takes redirect_pc.
